// File: rtl/sync_tdp_ram_param_be.sv
// rtl/sync_tdp_ram_param_be.sv - single-clock true dual-port RAM with byte enables and registered outputs
//
// Purpose:
//   Generic shared buffer. Two independent read/write ports on one clock, with
//   per-byte write enables and a per-port read-during-write mode. Same-address
//   cross-port conflicts are resolved deterministically (port A wins shared
//   bytes) and flagged on `collision`. An optional clear engine zeroes the
//   array after reset.
//
// Optional feature macro: TDP_RAM_OUT_PIPE_EN
//   Defined   -> one extra output register stage; read latency 2, with valid
//                and collision delayed to stay aligned with the data.
//   Undefined -> read latency 1.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   en_a, we_a, be_a, addr_a, data_a port A request
//   q_a, valid_a                     port A registered read data and strobe
//   en_b, we_b, be_b, addr_b, data_b port B request
//   q_b, valid_b                     port B registered read data and strobe
//   init_busy                        clear engine running, requests ignored
//   collision                        pulse: same-address conflict on an access

module sync_tdp_ram_param_be #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int RDW_MODE_A     = 0,
  parameter int RDW_MODE_B     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  output logic [DATA_WIDTH-1:0]   q_a,
  output logic                    valid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   data_b,
  output logic [DATA_WIDTH-1:0]   q_b,
  output logic                    valid_b,
  output logic                    init_busy,
  output logic                    collision
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    run;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    acc_a;
  logic                    acc_b;
  logic                    wr_a;
  logic                    wr_b;
  logic                    wr_b_eff;
  logic                    same_addr;
  logic [DATA_WIDTH-1:0]   old_a;
  logic [DATA_WIDTH-1:0]   old_b;
  logic [DATA_WIDTH-1:0]   merged_a;
  logic [DATA_WIDTH-1:0]   merged_b;
  logic [DATA_WIDTH-1:0]   rd_a_next;
  logic [DATA_WIDTH-1:0]   rd_b_next;
  logic                    col_next;

  logic [DATA_WIDTH-1:0]   q_a_r;
  logic [DATA_WIDTH-1:0]   q_b_r;
  logic                    valid_a_r;
  logic                    valid_b_r;
  logic                    col_r;

  // ---------------------------------------------------------------------------
  // Control FSM: state register and clear counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    run        = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request qualification and conflict detection
  // ---------------------------------------------------------------------------
  assign acc_a     = run & en_a;
  assign acc_b     = run & en_b;
  assign wr_a      = acc_a & we_a;
  assign wr_b      = acc_b & we_b;
  assign same_addr = (addr_a == addr_b);

  // When both ports write one word, port A's merged word already carries B's
  // bytes, so B's own write is suppressed to keep a single writer per word.
  assign wr_b_eff  = wr_b & ~(wr_a & same_addr);

  assign col_next  = acc_a & acc_b & same_addr & (we_a | we_b);

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  // Byte merge. merged_a is the final stored word at addr_a in every case:
  // A's enabled bytes first, then bytes only B enables on a shared address,
  // then the old contents.
  always_comb begin
    merged_a = old_a;
    merged_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) begin
        merged_a[8*i +: 8] = data_a[8*i +: 8];
      end else if (wr_b && same_addr && be_b[i]) begin
        merged_a[8*i +: 8] = data_b[8*i +: 8];
      end
      if (be_b[i]) begin
        merged_b[8*i +: 8] = data_b[8*i +: 8];
      end
    end
  end

  // Read data selection. A reading port always sees the pre-write word; a
  // WRITE_FIRST writer sees the arbitrated stored word.
  always_comb begin
    rd_a_next = old_a;
    rd_b_next = old_b;
    if (we_a && (RDW_MODE_A == 0)) begin
      rd_a_next = merged_a;
    end
    if (we_b && (RDW_MODE_B == 0)) begin
      rd_b_next = (wr_a && same_addr) ? merged_a : merged_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: not reset; the clear engine owns it during INIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_a) begin
        mem[addr_a] <= merged_a;
      end
      if (wr_b_eff) begin
        mem[addr_b] <= merged_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_r     <= '0;
      q_b_r     <= '0;
      valid_a_r <= 1'b0;
      valid_b_r <= 1'b0;
      col_r     <= 1'b0;
    end else begin
      valid_a_r <= acc_a;
      valid_b_r <= acc_b;
      col_r     <= col_next;
      if (acc_a) begin
        q_a_r <= rd_a_next;
      end
      if (acc_b) begin
        q_b_r <= rd_b_next;
      end
    end
  end

`ifdef TDP_RAM_OUT_PIPE_EN
  // ---------------------------------------------------------------------------
  // Extra output stage; q holds naturally because stage one holds when idle
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] q_a_p;
  logic [DATA_WIDTH-1:0] q_b_p;
  logic                  valid_a_p;
  logic                  valid_b_p;
  logic                  col_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a_p     <= '0;
      q_b_p     <= '0;
      valid_a_p <= 1'b0;
      valid_b_p <= 1'b0;
      col_p     <= 1'b0;
    end else begin
      q_a_p     <= q_a_r;
      q_b_p     <= q_b_r;
      valid_a_p <= valid_a_r;
      valid_b_p <= valid_b_r;
      col_p     <= col_r;
    end
  end

  assign q_a       = q_a_p;
  assign q_b       = q_b_p;
  assign valid_a   = valid_a_p;
  assign valid_b   = valid_b_p;
  assign collision = col_p;
`else
  assign q_a       = q_a_r;
  assign q_b       = q_b_r;
  assign valid_a   = valid_a_r;
  assign valid_b   = valid_b_r;
  assign collision = col_r;
`endif

endmodule

// File: tb/tb_sync_tdp_ram_param_be.sv
// tb/tb_sync_tdp_ram_param_be.sv - self-checking bench for sync_tdp_ram_param_be

module tb_sync_tdp_ram_param_be;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int RDW_A = 0;
  localparam int RDW_B = 1;
`ifdef TDP_RAM_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [1:0]    be_a = 2'b00, be_b = 2'b00;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic [DW-1:0] q_a, q_b;
  logic          valid_a, valid_b, init_busy, collision;

  always #5 clk = ~clk;

  sync_tdp_ram_param_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE_A(RDW_A), .RDW_MODE_B(RDW_B), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
    .q_a(q_a), .valid_a(valid_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
    .q_b(q_b), .valid_b(valid_b),
    .init_busy(init_busy), .collision(collision)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: word array plus the values each output should show.
  logic [DW-1:0] mm [DEPTH];
  int            init_left;
  logic [DW-1:0] m_qa, m_qb, p_qa, p_qb;
  logic          m_va, m_vb, m_col, p_va, p_vb, p_col;

  typedef struct {
    logic ea; logic wa; logic [1:0] ba; logic [3:0] aa; logic [15:0] da;
    logic eb; logic wb; logic [1:0] bb; logic [3:0] ab; logic [15:0] db;
    logic [15:0] qa; logic va; logic [15:0] qb; logic vb; logic col;
    logic cqa; logic cqb;
  } vec_t;

  vec_t tbl [14];

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_qa = '0; m_qb = '0; p_qa = '0; p_qb = '0;
    m_va = 1'b0; m_vb = 1'b0; m_col = 1'b0;
    p_va = 1'b0; p_vb = 1'b0; p_col = 1'b0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
  endtask

  // Called right after an active edge; holds reset across one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    model_reset();
    #2;
    chk16("rst_q_a", q_a, 16'h0000);
    chk16("rst_q_b", q_b, 16'h0000);
    chk1("rst_valid_a", valid_a, 1'b0);
    chk1("rst_valid_b", valid_b, 1'b0);
    chk1("rst_collision", collision, 1'b0);
    chk1("rst_init_busy", init_busy, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: apply request, advance model, compare every output.
  task automatic drive(input logic ea, input logic wa, input logic [1:0] ba, input logic [3:0] aa,
                       input logic [15:0] da,
                       input logic eb, input logic wb, input logic [1:0] bb, input logic [3:0] ab,
                       input logic [15:0] db);
    logic [15:0] oa, ob, nqa, nqb;
    logic        nva, nvb, ncol;
    @(negedge clk);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
    nqa = m_qa; nqb = m_qb; nva = 1'b0; nvb = 1'b0; ncol = 1'b0;
    if (init_left > 0) begin
      init_left--;
    end else begin
      oa = mm[aa];
      ob = mm[ab];
      // B first, then A on top: A owns any byte both ports enable.
      if (eb && wb) for (int i = 0; i < 2; i++) if (bb[i]) mm[ab][8*i +: 8] = db[8*i +: 8];
      if (ea && wa) for (int i = 0; i < 2; i++) if (ba[i]) mm[aa][8*i +: 8] = da[8*i +: 8];
      if (ea) nqa = (wa && RDW_A == 0) ? mm[aa] : oa;
      if (eb) nqb = (wb && RDW_B == 0) ? mm[ab] : ob;
      nva  = ea;
      nvb  = eb;
      ncol = ea && eb && (aa == ab) && (wa || wb);
    end
    p_qa = m_qa; p_qb = m_qb; p_va = m_va; p_vb = m_vb; p_col = m_col;
    m_qa = nqa;  m_qb = nqb;  m_va = nva;  m_vb = nvb;  m_col = ncol;
    @(posedge clk); #1;
    chk16("model_q_a", q_a, (LAT == 1) ? m_qa : p_qa);
    chk16("model_q_b", q_b, (LAT == 1) ? m_qb : p_qb);
    chk1("model_valid_a", valid_a, (LAT == 1) ? m_va : p_va);
    chk1("model_valid_b", valid_b, (LAT == 1) ? m_vb : p_vb);
    chk1("model_collision", collision, (LAT == 1) ? m_col : p_col);
    chk1("model_init_busy", init_busy, init_left > 0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0000);
  endtask

  initial begin
    int cyc;
    logic [3:0] ra, rb;

    tbl[0]  = '{1'b1,1'b1,2'b11,4'd3,16'hBEEF, 1'b0,1'b0,2'b00,4'd0,16'h0000, 16'hBEEF,1'b1,16'h0000,1'b0,1'b0, 1'b1,1'b0};
    tbl[1]  = '{1'b0,1'b0,2'b00,4'd0,16'h0000, 1'b1,1'b0,2'b00,4'd3,16'h0000, 16'h0000,1'b0,16'hBEEF,1'b1,1'b0, 1'b0,1'b1};
    tbl[2]  = '{1'b1,1'b1,2'b11,4'd5,16'h1234, 1'b0,1'b0,2'b00,4'd0,16'h0000, 16'h1234,1'b1,16'h0000,1'b0,1'b0, 1'b1,1'b0};
    tbl[3]  = '{1'b1,1'b1,2'b10,4'd5,16'hAB00, 1'b0,1'b0,2'b00,4'd0,16'h0000, 16'hAB34,1'b1,16'h0000,1'b0,1'b0, 1'b1,1'b0};
    tbl[4]  = '{1'b0,1'b0,2'b00,4'd0,16'h0000, 1'b1,1'b1,2'b10,4'd5,16'hCD00, 16'h0000,1'b0,16'hAB34,1'b1,1'b0, 1'b0,1'b1};
    tbl[5]  = '{1'b1,1'b0,2'b00,4'd5,16'h0000, 1'b0,1'b0,2'b00,4'd0,16'h0000, 16'hCD34,1'b1,16'h0000,1'b0,1'b0, 1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b1,2'b01,4'd7,16'h1111, 1'b1,1'b1,2'b11,4'd7,16'h2222, 16'h2211,1'b1,16'h0000,1'b1,1'b1, 1'b1,1'b1};
    tbl[7]  = '{1'b1,1'b1,2'b11,4'd7,16'h5555, 1'b1,1'b0,2'b00,4'd7,16'h0000, 16'h5555,1'b1,16'h2211,1'b1,1'b1, 1'b1,1'b1};
    tbl[8]  = '{1'b1,1'b0,2'b00,4'd7,16'h0000, 1'b1,1'b0,2'b00,4'd7,16'h0000, 16'h5555,1'b1,16'h5555,1'b1,1'b0, 1'b1,1'b1};
    tbl[9]  = '{1'b1,1'b1,2'b00,4'd9,16'hFFFF, 1'b0,1'b0,2'b00,4'd0,16'h0000, 16'h0000,1'b1,16'h0000,1'b0,1'b0, 1'b1,1'b0};
    tbl[10] = '{1'b1,1'b0,2'b00,4'd9,16'h0000, 1'b1,1'b1,2'b01,4'd9,16'h77AA, 16'h0000,1'b1,16'h0000,1'b1,1'b1, 1'b1,1'b1};
    tbl[11] = '{1'b1,1'b0,2'b00,4'd9,16'h0000, 1'b1,1'b0,2'b00,4'd10,16'h0000, 16'h00AA,1'b1,16'h0000,1'b1,1'b0, 1'b1,1'b1};
    tbl[12] = '{1'b1,1'b1,2'b11,4'd2,16'h0102, 1'b1,1'b1,2'b01,4'd2,16'h0304, 16'h0102,1'b1,16'h0000,1'b1,1'b1, 1'b1,1'b1};
    tbl[13] = '{1'b1,1'b1,2'b01,4'd2,16'h00FF, 1'b1,1'b1,2'b10,4'd2,16'hEE00, 16'hEEFF,1'b1,16'h0102,1'b1,1'b1, 1'b1,1'b1};

    // Reset and full clear: busy for exactly DEPTH cycles.
    do_reset();
    cyc = 0;
    do begin
      idle();
      cyc++;
    end while (init_busy && cyc < 40);
    chk16("init_len", 16'(cyc), 16'd16);

    // Every word reads back zero on both ports.
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 2'b00, 4'(i), 16'h0000, 1'b1, 1'b0, 2'b00, 4'(DEPTH-1-i), 16'h0000);
    idle();

    // Directed table; with the output pipe an idle cycle brings the result out.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].ea, tbl[i].wa, tbl[i].ba, tbl[i].aa, tbl[i].da,
            tbl[i].eb, tbl[i].wb, tbl[i].bb, tbl[i].ab, tbl[i].db);
      if (LAT == 2) idle();
      if (tbl[i].cqa) chk16($sformatf("tbl%0d_q_a", i), q_a, tbl[i].qa);
      if (tbl[i].cqb) chk16($sformatf("tbl%0d_q_b", i), q_b, tbl[i].qb);
      chk1($sformatf("tbl%0d_valid_a", i), valid_a, tbl[i].va);
      chk1($sformatf("tbl%0d_valid_b", i), valid_b, tbl[i].vb);
      chk1($sformatf("tbl%0d_collision", i), collision, tbl[i].col);
    end

    // Back-to-back conflicts followed by idle: pulses then hold.
    drive(1'b1, 1'b1, 2'b11, 4'd4, 16'hA5A5, 1'b1, 1'b0, 2'b00, 4'd4, 16'h0000);
    drive(1'b1, 1'b0, 2'b00, 4'd4, 16'h0000, 1'b1, 1'b1, 2'b01, 4'd4, 16'h005A);
    for (int i = 0; i < 3; i++) idle();
    chk16("idle_hold_q_a", q_a, 16'hA5A5);
    chk1("idle_valid_a", valid_a, 1'b0);

    // Randomized traffic, biased to a few addresses to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
            16'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), rb, 16'($urandom));
    end

    // Reset in the middle of a clear restarts it from address 0.
    do_reset();
    for (int i = 0; i < 9; i++) idle();
    do_reset();
    cyc = 0;
    do begin
      idle();
      cyc++;
    end while (init_busy && cyc < 40);
    chk16("restart_len", 16'(cyc), 16'd16);
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 2'b00, 4'(i), 16'h0000, 1'b1, 1'b0, 2'b00, 4'(i), 16'h0000);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
